// File: rtl/writeback_unit_if.sv
// writeback_unit_if
// Bundles the signals between the writeback unit and its neighbours:
//   - memory (load) result channel: mem_valid/mem_rd/mem_data in, mem_ready out
//   - ALU result channel:           alu_valid/alu_rd/alu_data in, alu_ready out
//   - register file write port:     we/wb_rd/wb_data out
//   - register file read ports:     rs_addr/rt_addr/rs_rf/rt_rf in,
//                                   rs_fwd/rt_fwd/hazard out
// Modport "slave" is the writeback unit. Modport "master" is the surrounding
// pipeline (execute/memory stages, register file and decode).
interface writeback_unit_if #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5
);
    logic                 mem_valid;
    logic [REG_WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0]     mem_data;
    logic                 mem_ready;

    logic                 alu_valid;
    logic [REG_WIDTH-1:0] alu_rd;
    logic [WIDTH-1:0]     alu_data;
    logic                 alu_ready;

    logic                 we;
    logic [REG_WIDTH-1:0] wb_rd;
    logic [WIDTH-1:0]     wb_data;

    logic [REG_WIDTH-1:0] rs_addr;
    logic [REG_WIDTH-1:0] rt_addr;
    logic [WIDTH-1:0]     rs_rf;
    logic [WIDTH-1:0]     rt_rf;
    logic [WIDTH-1:0]     rs_fwd;
    logic [WIDTH-1:0]     rt_fwd;
    logic                 hazard;

    modport slave (
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        output we, wb_rd, wb_data,
        input  rs_addr, rt_addr, rs_rf, rt_rf,
        output rs_fwd, rt_fwd, hazard
    );

    modport master (
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        input  we, wb_rd, wb_data,
        output rs_addr, rt_addr, rs_rf, rt_rf,
        input  rs_fwd, rt_fwd, hazard
    );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit
// Collects load and ALU results, keeps them in arrival order (load before
// ALU when both arrive together) in a small FIFO, and issues one registered
// register-file write per cycle. Also checks register-file read addresses
// against results that have not landed yet.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high
//   bus    - writeback_unit_if.slave (result channels, write port, read ports)
//   count  - FIFO occupancy (registered; the output register is not counted)
// Build option:
//   WB_FORWARD_EN defined   - rs_fwd/rt_fwd carry the youngest pending value,
//                             hazard is tied to 0.
//   WB_FORWARD_EN undefined - rs_fwd/rt_fwd pass the register file through,
//                             hazard flags any pending match.
module writeback_unit #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    writeback_unit_if.slave        bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_WIDTH-1:0] fifoRd   [DEPTH];
    logic [WIDTH-1:0]     fifoData [DEPTH];

    logic [PW-1:0]        headReg, headNext, tailReg, tailNext, tailPlusOne;
    logic [CW-1:0]        countReg, countNext;
    logic                 weReg, weNext;
    logic [REG_WIDTH-1:0] wbRdReg, wbRdNext;
    logic [WIDTH-1:0]     wbDataReg, wbDataNext;

    logic                 memReady, aluReady, memKeep, aluKeep;
    logic                 pushA, pushB, pop;
    logic [1:0]           numPush;
    logic [REG_WIDTH-1:0] pushARd;
    logic [WIDTH-1:0]     pushAData;

    // Readiness looks only at registered occupancy. With DEPTH-1 entries a
    // lone load can still be pushed while one entry drains, so the FIFO can
    // never overflow even though the drain is not credited here.
    assign memReady = countReg < CW'(DEPTH);
    assign aluReady = countReg < CW'(DEPTH - 1);

    // Results for r0 complete the handshake but are dropped here.
    assign memKeep = bus.mem_valid && memReady && (bus.mem_rd != '0);
    assign aluKeep = bus.alu_valid && aluReady && (bus.alu_rd != '0);

    // Oldest pending result goes to the output register; everything else
    // accepted this cycle is pushed in arrival order (load first). The
    // second push slot, when used, always carries the ALU result.
    always_comb begin
        weNext     = 1'b0;
        wbRdNext   = wbRdReg;
        wbDataNext = wbDataReg;
        pop        = 1'b0;
        pushA      = 1'b0;
        pushB      = 1'b0;
        pushARd    = bus.mem_rd;
        pushAData  = bus.mem_data;
        if (countReg != '0) begin
            weNext     = 1'b1;
            wbRdNext   = fifoRd[headReg];
            wbDataNext = fifoData[headReg];
            pop        = 1'b1;
            pushA      = memKeep || aluKeep;
            pushB      = memKeep && aluKeep;
            if (!memKeep) begin
                pushARd   = bus.alu_rd;
                pushAData = bus.alu_data;
            end
        end else if (memKeep) begin
            weNext     = 1'b1;
            wbRdNext   = bus.mem_rd;
            wbDataNext = bus.mem_data;
            pushA      = aluKeep;
            pushARd    = bus.alu_rd;
            pushAData  = bus.alu_data;
        end else if (aluKeep) begin
            weNext     = 1'b1;
            wbRdNext   = bus.alu_rd;
            wbDataNext = bus.alu_data;
        end
    end

    assign numPush     = {1'b0, pushA} + {1'b0, pushB};
    assign tailPlusOne = tailReg + PW'(1);
    assign tailNext    = tailReg + PW'(numPush);
    assign headNext    = headReg + PW'(pop);
    assign countNext   = countReg + CW'(numPush) - CW'(pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            headReg   <= '0;
            tailReg   <= '0;
            countReg  <= '0;
            weReg     <= 1'b0;
            wbRdReg   <= '0;
            wbDataReg <= '0;
        end else begin
            headReg   <= headNext;
            tailReg   <= tailNext;
            countReg  <= countNext;
            weReg     <= weNext;
            wbRdReg   <= wbRdNext;
            wbDataReg <= wbDataNext;
        end
    end

    // Entry storage needs no reset: liveness comes from head/count.
    always_ff @(posedge clock) begin
        if (pushA) begin
            fifoRd[tailReg]   <= pushARd;
            fifoData[tailReg] <= pushAData;
        end
        if (pushB) begin
            fifoRd[tailPlusOne]   <= bus.alu_rd;
            fifoData[tailPlusOne] <= bus.alu_data;
        end
    end

    assign bus.mem_ready = memReady;
    assign bus.alu_ready = aluReady;
    assign bus.we        = weReg;
    assign bus.wb_rd     = wbRdReg;
    assign bus.wb_data   = wbDataReg;
    assign count         = countReg;

    // Hazard matching: entry gi is the gi-th oldest FIFO entry.
    logic [PW-1:0]    entIdx [DEPTH];
    logic [DEPTH-1:0] rsMatch, rtMatch;
    logic             rsOutMatch, rtOutMatch;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic live;
        assign entIdx[gi]  = headReg + PW'(gi);
        assign live        = CW'(gi) < countReg;
        assign rsMatch[gi] = live && (fifoRd[entIdx[gi]] == bus.rs_addr)
                             && (bus.rs_addr != '0);
        assign rtMatch[gi] = live && (fifoRd[entIdx[gi]] == bus.rt_addr)
                             && (bus.rt_addr != '0);
    end

    // The output register lands at the coming edge, so the value currently
    // read from the register file for that address is stale.
    assign rsOutMatch = weReg && (wbRdReg == bus.rs_addr) && (bus.rs_addr != '0);
    assign rtOutMatch = weReg && (wbRdReg == bus.rt_addr) && (bus.rt_addr != '0);

`ifdef WB_FORWARD_EN
    logic [WIDTH-1:0] rsVal, rtVal;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        rsVal = bus.rs_rf;
        rtVal = bus.rt_rf;
        if (rsOutMatch) rsVal = wbDataReg;
        if (rtOutMatch) rtVal = wbDataReg;
        for (int k = 0; k < DEPTH; k++) begin
            if (rsMatch[k]) rsVal = fifoData[entIdx[k]];
            if (rtMatch[k]) rtVal = fifoData[entIdx[k]];
        end
    end

    assign bus.rs_fwd = rsVal;
    assign bus.rt_fwd = rtVal;
    assign bus.hazard = 1'b0;
`else
    assign bus.rs_fwd = bus.rs_rf;
    assign bus.rt_fwd = bus.rt_rf;
    assign bus.hazard = rsOutMatch || rtOutMatch || (|rsMatch) || (|rtMatch);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NVEC = 18;

    logic       clock;
    logic       reset;
    logic [2:0] count;

    writeback_unit_if #(.WIDTH(32), .REG_WIDTH(5)) bus ();

    writeback_unit #(.WIDTH(32), .REG_WIDTH(5), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic [4:0]  rsa;
        logic [31:0] rsrf;
        logic [4:0]  rta;
        logic [31:0] rtrf;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [2:0]  ecnt;
        logic [31:0] ersf;
        logic [31:0] ertf;
        logic        ehz;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic [4:0] rsa, logic [31:0] rsrf,
                                logic [4:0] rta, logic [31:0] rtrf,
                                logic ewe, logic [4:0] erd, logic [31:0] edata,
                                logic [2:0] ecnt, logic [31:0] ersf,
                                logic [31:0] ertf, logic ehz);
        vec_t v;
        v.mv = mv;   v.mrd = mrd;   v.md = md;
        v.av = av;   v.ard = ard;   v.ad = ad;
        v.rsa = rsa; v.rsrf = rsrf; v.rta = rta; v.rtrf = rtrf;
        v.ewe = ewe; v.erd = erd;   v.edata = edata; v.ecnt = ecnt;
        v.ersf = ersf; v.ertf = ertf; v.ehz = ehz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.rs_addr = 5'd1; bus.rs_rf = 32'h100;
        bus.rt_addr = 5'd2; bus.rt_rf = 32'h200;
    endtask

    int           mi, ai, written, exp_rd;
    bit           saw_alu_drop;
    logic [4:0]   expq [$];

    initial begin
        // Rows are sampled mid-cycle: registered outputs reflect earlier rows.
        //            mv mrd   md      av ard   ad          rsa   rsrf     rta   rtrf     we rd    data           cnt  rs_fwd               rt_fwd               hazard
        for (int i = 0; i < 5; i++)
            vecs[i] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,       5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd0, 32'h0,        3'd0, 32'h100,             32'h200,             0);
        vecs[5]  = mk(0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF,  5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd0, 32'h0,        3'd0, 32'h100,             32'h200,             0);
        vecs[6]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 1, 5'd5, 32'hDEADBEEF, 3'd0, 32'h100,             32'h200,             0);
        vecs[7]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd5, 32'hDEADBEEF, 3'd0, 32'h100,             32'h200,             0);
        vecs[8]  = mk(1, 5'd3, 32'h11, 1, 5'd4, 32'h22,        5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd5, 32'hDEADBEEF, 3'd0, 32'h100,             32'h200,             0);
        vecs[9]  = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 1, 5'd3, 32'h11,       3'd1, 32'h100,             32'h200,             0);
        vecs[10] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 1, 5'd4, 32'h22,       3'd0, 32'h100,             32'h200,             0);
        vecs[11] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd4, 32'h22,       3'd0, 32'h100,             32'h200,             0);
        vecs[12] = mk(0, 5'd0, 32'h0,  1, 5'd0, 32'h99,        5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd4, 32'h22,       3'd0, 32'h100,             32'h200,             0);
        vecs[13] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd1, 32'h100, 5'd2, 32'h200, 0, 5'd4, 32'h22,       3'd0, 32'h100,             32'h200,             0);
        vecs[14] = mk(1, 5'd7, 32'hA,  1, 5'd7, 32'hB,         5'd7, 32'h0,   5'd9, 32'h55,  0, 5'd4, 32'h22,       3'd0, 32'h0,               32'h55,              0);
        vecs[15] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd7, 32'h0,   5'd9, 32'h55,  1, 5'd7, 32'hA,        3'd1, FWD ? 32'hB : 32'h0, 32'h55,              !FWD);
        vecs[16] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd9, 32'h66,  5'd7, 32'h77,  1, 5'd7, 32'hB,        3'd0, 32'h66,              FWD ? 32'hB : 32'h77, !FWD);
        vecs[17] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         5'd7, 32'h0,   5'd7, 32'h77,  0, 5'd7, 32'hB,        3'd0, 32'h0,               32'h77,              0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven part: reset/idle, single ALU, simultaneous, r0, forwarding.
        for (int i = 0; i < NVEC; i++) begin
            bus.mem_valid = vecs[i].mv;  bus.mem_rd = vecs[i].mrd; bus.mem_data = vecs[i].md;
            bus.alu_valid = vecs[i].av;  bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].ad;
            bus.rs_addr = vecs[i].rsa;   bus.rs_rf = vecs[i].rsrf;
            bus.rt_addr = vecs[i].rta;   bus.rt_rf = vecs[i].rtrf;
            @(negedge clock);
            chk($sformatf("vec%0d_we", i),        32'(bus.we),        32'(vecs[i].ewe));
            chk($sformatf("vec%0d_wb_rd", i),     32'(bus.wb_rd),     32'(vecs[i].erd));
            chk($sformatf("vec%0d_wb_data", i),   bus.wb_data,        vecs[i].edata);
            chk($sformatf("vec%0d_count", i),     32'(count),         32'(vecs[i].ecnt));
            chk($sformatf("vec%0d_mem_ready", i), 32'(bus.mem_ready), 32'd1);
            chk($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready), 32'd1);
            chk($sformatf("vec%0d_rs_fwd", i),    bus.rs_fwd,         vecs[i].ersf);
            chk($sformatf("vec%0d_rt_fwd", i),    bus.rt_fwd,         vecs[i].ertf);
            chk($sformatf("vec%0d_hazard", i),    32'(bus.hazard),    32'(vecs[i].ehz));
            $display("vec %0d: we=%0b rd=%0d data=%h count=%0d rs_fwd=%h rt_fwd=%h hazard=%0b",
                     i, bus.we, bus.wb_rd, bus.wb_data, count, bus.rs_fwd, bus.rt_fwd, bus.hazard);
            @(posedge clock);
            #1;
        end
        idle_inputs();

        // Fill: loads carry odd destinations, ALU results even ones; each
        // source holds its item until accepted. Write data = 0x1000 + rd.
        mi = 1; ai = 2; written = 0; saw_alu_drop = 1'b0;
        for (int cyc = 0; cyc < 60 && written < 16; cyc++) begin
            bus.mem_valid = (mi <= 15); bus.mem_rd = mi[4:0]; bus.mem_data = 32'h1000 + 32'(mi);
            bus.alu_valid = (ai <= 16); bus.alu_rd = ai[4:0]; bus.alu_data = 32'h1000 + 32'(ai);
            @(negedge clock);
            if (bus.we) begin
                if (expq.size() == 0) begin
                    chk("fill_unexpected_write", 32'(bus.we), 32'd0);
                end else begin
                    exp_rd = int'(expq.pop_front());
                    chk("fill_wb_rd", 32'(bus.wb_rd), 32'(exp_rd));
                    chk("fill_wb_data", bus.wb_data, 32'h1000 + 32'(exp_rd));
                    written++;
                    $display("fill write %0d: rd=%0d data=%h count=%0d", written, bus.wb_rd, bus.wb_data, count);
                end
            end
            chk("fill_count", 32'(count), 32'(expq.size()));
            chk("fill_mem_ready", 32'(bus.mem_ready), 32'(expq.size() < 4));
            chk("fill_alu_ready", 32'(bus.alu_ready), 32'(expq.size() < 3));
            if (!bus.alu_ready && bus.mem_ready) saw_alu_drop = 1'b1;
            if (bus.mem_valid && bus.mem_ready) begin expq.push_back(mi[4:0]); mi += 2; end
            if (bus.alu_valid && bus.alu_ready) begin expq.push_back(ai[4:0]); ai += 2; end
            @(posedge clock);
            #1;
        end
        chk("fill_all_written", 32'(written), 32'd16);
        chk("fill_alu_ready_dropped", 32'(saw_alu_drop), 32'd1);
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;

        // Reset mid-stream: rd 20..22 get written, 23..25 sit in the FIFO.
        for (int k = 0; k < 3; k++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(20 + 2 * k); bus.mem_data = 32'h2000 + 32'(20 + 2 * k);
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(21 + 2 * k); bus.alu_data = 32'h2000 + 32'(21 + 2 * k);
            @(posedge clock);
            #1;
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_pre_count", 32'(count), 32'd3);
        $display("reset asserted with count=%0d", count);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("rst_idle%0d_we", k), 32'(bus.we), 32'd0);
            chk($sformatf("rst_idle%0d_count", k), 32'(count), 32'd0);
            $display("post-reset idle %0d: we=%0b count=%0d", k, bus.we, count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
